our_relay: RTL and testbench
============================

OUR_RELAY -- requirements
Module: our_relay

Interface
REQ-001 Parameter PULL_IN_CYCLES, default 2: consecutive sampled-high coil cycles needed to close the contact; legal range 1..255.
REQ-002 Parameter DROP_OUT_CYCLES, default 1: consecutive sampled-low coil cycles needed to open the contact; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 out  output  1  relay contact output; carries batt while the contact is closed, else 0.
REQ-006 switch  input  1  coil drive; 1 = energized. Synchronous to clk.
REQ-007 batt  input  1  supply fed through the contact.
REQ-008 energized  output  1  registered armature state; 1 = contact closed.
REQ-009 The port order is clk, rst_n, out, switch, batt, energized.

Function
REQ-010 The relay SHALL be a four-state FSM: OPEN, PULLING, CLOSED, RELEASING, with an 8-bit cycle counter.
REQ-011 OPEN: if switch==1, go to PULLING with counter=1; if PULL_IN_CYCLES==1, go directly to CLOSED instead.
REQ-012 PULLING: if switch==1 and counter+1==PULL_IN_CYCLES, go to CLOSED; if switch==1 otherwise, increment counter; if switch==0, go to OPEN and clear counter (no partial pull-in is retained).
REQ-013 CLOSED: if switch==0, go to RELEASING with counter=1; if DROP_OUT_CYCLES==1, go directly to OPEN instead; if switch==1, stay.
REQ-014 RELEASING: if switch==0 and counter+1==DROP_OUT_CYCLES, go to OPEN; if switch==0 otherwise, increment counter; if switch==1, return to CLOSED and clear counter.
REQ-015 energized SHALL be 1 exactly in states CLOSED and RELEASING, and SHALL be driven from a register.
REQ-016 out SHALL equal energized AND batt, combinationally in batt; a batt change is visible on out in the same cycle with no clock edge.
REQ-017 Net latency: contact closes on the PULL_IN_CYCLES-th consecutive rising edge at which switch is 1, and opens on the DROP_OUT_CYCLES-th consecutive rising edge at which switch is 0.
REQ-018 Pulses on switch shorter than PULL_IN_CYCLES cycles SHALL NOT change out; dropouts shorter than DROP_OUT_CYCLES cycles SHALL NOT open the contact.
REQ-019 The counter SHALL never exceed max(PULL_IN_CYCLES, DROP_OUT_CYCLES) and never wraps.
REQ-020 Cascading (out of one instance driving switch of the next) SHALL add the per-stage latency with no combinational loop, since out depends combinationally only on batt.
REQ-021 X or Z on switch SHALL be treated as 0 (de-energized).

Reset
REQ-022 While rst_n==0: state=OPEN, counter=0, energized=0, out=0, independent of clk, switch and batt.
REQ-023 rst_n asserted mid-PULLING or mid-RELEASING SHALL abort immediately to OPEN.
REQ-024 After rst_n deasserts, the first rising edge SHALL evaluate switch per REQ-011; a held-high switch closes the contact only after a full PULL_IN_CYCLES count.

Verification (defaults PULL_IN=2, DROP_OUT=1, batt=1 unless stated)
REQ-025 Reset: rst_n=0 with switch=1, batt=1 -> out=0 and energized=0 for the whole reset period.
REQ-026 Pull-in: switch 0->1 held -> out=0 after the 1st edge and out=1 after the 2nd edge; switch 1->0 -> out=0 after the next edge.
REQ-027 Glitch reject: 1-cycle switch pulse -> out stays 0; with DROP_OUT=3, a 2-cycle low while CLOSED -> out stays 1.
REQ-028 Supply gating: CLOSED, batt toggles 1->0->1 between edges -> out follows batt immediately; energized stays 1.
REQ-029 Two-stage cascade: stage1 switch 0->1 at t0 -> stage1 out=1 after 2 edges, stage2 out=1 after 4 edges; stage1 switch 1->0 -> stage2 out=0 after 2 edges.
REQ-030 Async reset mid-PULLING: rst_n pulsed low between edges -> energized=0 at once; re-pull needs 2 fresh edges with switch=1.

Source files
------------

// File: rtl/our_relay.sv
// Electromechanical relay model: debounced coil (pull-in / drop-out counts)
// drives a registered armature; the contact passes batt while closed.
module our_relay #(
    parameter int unsigned PULL_IN_CYCLES  = 2,
    parameter int unsigned DROP_OUT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic out,
    input  logic switch,
    input  logic batt,
    output logic energized
);

    typedef enum logic [1:0] {
        S_OPEN,
        S_PULLING,
        S_CLOSED,
        S_RELEASING
    } state_t;

    localparam logic [7:0] PULL_N = 8'(PULL_IN_CYCLES);
    localparam logic [7:0] DROP_N = 8'(DROP_OUT_CYCLES);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_energized;
    logic       w_sw;
    logic [7:0] w_cnt_inc;

    // Anything but a clean 1 on the coil counts as de-energized.
    assign w_sw      = (switch === 1'b1);
    assign w_cnt_inc = r_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_OPEN;
            r_cnt       <= '0;
            r_energized <= 1'b0;
        end else begin
            unique case (r_state)
                S_OPEN: begin
                    if (w_sw) begin
                        if (PULL_N == 8'd1) begin
                            r_state     <= S_CLOSED;
                            r_cnt       <= '0;
                            r_energized <= 1'b1;
                        end else begin
                            r_state     <= S_PULLING;
                            r_cnt       <= 8'd1;
                            r_energized <= 1'b0;
                        end
                    end else begin
                        r_cnt       <= '0;
                        r_energized <= 1'b0;
                    end
                end
                S_PULLING: begin
                    if (w_sw && (w_cnt_inc == PULL_N)) begin
                        r_state     <= S_CLOSED;
                        r_cnt       <= '0;
                        r_energized <= 1'b1;
                    end else if (w_sw) begin
                        r_cnt       <= w_cnt_inc;
                    end else begin
                        r_state     <= S_OPEN;
                        r_cnt       <= '0;
                        r_energized <= 1'b0;
                    end
                end
                S_CLOSED: begin
                    if (!w_sw) begin
                        if (DROP_N == 8'd1) begin
                            r_state     <= S_OPEN;
                            r_cnt       <= '0;
                            r_energized <= 1'b0;
                        end else begin
                            r_state     <= S_RELEASING;
                            r_cnt       <= 8'd1;
                            r_energized <= 1'b1;
                        end
                    end else begin
                        r_cnt       <= '0;
                        r_energized <= 1'b1;
                    end
                end
                S_RELEASING: begin
                    if (!w_sw && (w_cnt_inc == DROP_N)) begin
                        r_state     <= S_OPEN;
                        r_cnt       <= '0;
                        r_energized <= 1'b0;
                    end else if (!w_sw) begin
                        r_cnt       <= w_cnt_inc;
                    end else begin
                        r_state     <= S_CLOSED;
                        r_cnt       <= '0;
                        r_energized <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_OPEN;
                    r_cnt       <= '0;
                    r_energized <= 1'b0;
                end
            endcase
        end
    end

    assign energized = r_energized;
    assign out       = r_energized & batt;

endmodule

// File: tb/tb_our_relay.sv
// Randomized bench for our_relay: four instances (incl. a two-stage cascade)
// compared against a run-length model of pull-in/drop-out behaviour.
module tb_our_relay;

    logic clk = 1'b0;
    logic rst_n, batt, sw_a, sw_b, sw_c;
    logic out_a, en_a, out_b, en_b, out_c, en_c, out_s, en_s;

    always #5 clk = ~clk;

    our_relay #(.PULL_IN_CYCLES(2), .DROP_OUT_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .out(out_a), .switch(sw_a), .batt(batt), .energized(en_a));
    our_relay #(.PULL_IN_CYCLES(3), .DROP_OUT_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .out(out_b), .switch(sw_b), .batt(batt), .energized(en_b));
    our_relay #(.PULL_IN_CYCLES(1), .DROP_OUT_CYCLES(1)) u_c (
        .clk(clk), .rst_n(rst_n), .out(out_c), .switch(sw_c), .batt(batt), .energized(en_c));
    our_relay #(.PULL_IN_CYCLES(2), .DROP_OUT_CYCLES(1)) u_s2 (
        .clk(clk), .rst_n(rst_n), .out(out_s), .switch(out_a), .batt(batt), .energized(en_s));

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0b exp=%0b t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: contact state plus length of the current run of "opposite" coil samples.
    bit          m_closed[4];
    int unsigned m_run[4];
    int unsigned MP[4] = '{2, 3, 1, 2};
    int unsigned MD[4] = '{1, 3, 1, 1};

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_closed[i] = 1'b0;
            m_run[i]    = 0;
        end
    endtask

    task automatic m_step(input int i, input bit sw);
        if (!m_closed[i]) begin
            m_run[i] = sw ? m_run[i] + 1 : 0;
            if (m_run[i] >= MP[i]) begin
                m_closed[i] = 1'b1;
                m_run[i]    = 0;
            end
        end else begin
            m_run[i] = !sw ? m_run[i] + 1 : 0;
            if (m_run[i] >= MD[i]) begin
                m_closed[i] = 1'b0;
                m_run[i]    = 0;
            end
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, "_en_a"},  en_a,  m_closed[0]);
        check({ph, "_out_a"}, out_a, m_closed[0] & batt);
        check({ph, "_en_b"},  en_b,  m_closed[1]);
        check({ph, "_out_b"}, out_b, m_closed[1] & batt);
        check({ph, "_en_c"},  en_c,  m_closed[2]);
        check({ph, "_out_c"}, out_c, m_closed[2] & batt);
        check({ph, "_en_s"},  en_s,  m_closed[3]);
        check({ph, "_out_s"}, out_s, m_closed[3] & batt);
    endtask

    // One clock: model the edge, check, optional batt toggle, drive next
    // switch values, optional async reset pulse between edges.
    task automatic cycle(input bit a, input bit b, input bit c, input bit tog, input bit rst);
        bit s2;
        @(posedge clk);
        if (rst_n) begin
            s2 = m_closed[0] & batt;
            m_step(0, sw_a);
            m_step(1, sw_b);
            m_step(2, sw_c);
            m_step(3, s2);
        end
        #2 check_all("edge");
        if (tog) begin
            batt = ~batt;
            #1 check_all("batt");
        end else begin
            #1;
        end
        sw_a = a;
        sw_b = b;
        sw_c = c;
        if (rst) begin
            #1 rst_n = 1'b0;
            m_reset();
            #1 check_all("arst");
            rst_n = 1'b1;
        end
    endtask

    bit ra, rb, rc;

    initial begin
        rst_n = 1'b0;
        sw_a  = 1'b1;
        sw_b  = 1'b1;
        sw_c  = 1'b1;
        batt  = 1'b1;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_en_a", en_a, 1'b0);
            check("rst_out_a", out_a, 1'b0);
            check("rst_en_c", en_c, 1'b0);
        end
        rst_n = 1'b1;

        // Held-high coil after reset: full pull-in count; then a short dropout on b.
        cycle(1, 1, 1, 0, 0);
        check("pull_e1_a", en_a, 1'b0);
        check("pull_e1_c", en_c, 1'b1);
        cycle(1, 1, 1, 0, 0);
        check("pull_e2_a", out_a, 1'b1);
        check("pull_e2_b", en_b, 1'b0);
        cycle(1, 0, 1, 0, 0);
        check("pull_e3_b", en_b, 1'b1);
        cycle(1, 0, 1, 0, 0);
        check("cascade_e4", out_s, 1'b1);
        cycle(0, 1, 1, 1, 0);
        check("supply_gate_en", en_a, 1'b1);
        check("supply_gate_out", out_a, 1'b0);
        cycle(1, 1, 1, 1, 0);
        check("dropout_a", en_a, 1'b0);
        check("glitch_b_held", en_b, 1'b1);
        cycle(1, 1, 1, 0, 1);
        check("arst_abort", en_a, 1'b0);

        ra = 1'b0;
        rb = 1'b0;
        rc = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3, 0) == 0) ra = ~ra;
            if ($urandom_range(3, 0) == 0) rb = ~rb;
            if ($urandom_range(2, 0) == 0) rc = ~rc;
            cycle(ra, rb, rc, ($urandom_range(5, 0) == 0), ($urandom_range(60, 0) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
